// File: rtl/uart_reg_responder.sv
// -----------------------------------------------------------------------------
// uart_reg_responder
//
// Host-side command responder for a byte-oriented serial link. Received bytes
// are parsed into register read/write request frames:
//
//   request : A5, CMD, ADDR, [DATA], CSUM
//             CMD 01 = write (carries DATA, CSUM = CMD^ADDR^DATA)
//             CMD 02 = read  (no DATA,      CSUM = CMD^ADDR)
//             any other CMD is parsed with the read length
//   response: 5A, CODE, PAYLOAD, CODE^PAYLOAD
//             CODE 00 ok, E1 bad checksum, E2 unknown CMD, E3 ADDR >= NREG
//             (priority E1 > E2 > E3, PAYLOAD 00 on any error)
//
// The link is half duplex: bytes arriving while a request is being executed
// or answered are dropped. A stalled request frame is abandoned after TIMEOUT
// idle clocks between bytes.
//
// Parameters:
//   NREG     number of 8-bit registers (1..256), addresses 0..NREG-1
//   TIMEOUT  idle clocks allowed between bytes of one request frame (>= 1)
//
// Ports:
//   clk       sole clock
//   rst       asynchronous, active-high reset
//   rx_vld    single-cycle strobe, rx_data holds a received byte
//   rx_data   received byte
//   txrdy     transmitter idle; drops the cycle after it takes a byte
//   tx_vld    registered single-cycle byte-send strobe
//   tx_data   registered byte to send, stable until the next strobe
//   reg_q     register bank, register i on bits [8i+7:8i]
//   wr_stb    one-cycle pulse for each committed register write
//   busy      high from request complete until the last response byte is sent
// -----------------------------------------------------------------------------
module uart_reg_responder #(
  parameter int NREG    = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_vld,
  input  logic [7:0]        rx_data,
  input  logic              txrdy,
  output logic              tx_vld,
  output logic [7:0]        tx_data,
  output logic [8*NREG-1:0] reg_q,
  output logic              wr_stb,
  output logic              busy
);

  // Width of the inter-byte timeout counter; it saturates at TIMEOUT.
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  localparam logic [7:0] REQ_SYNC  = 8'hA5;
  localparam logic [7:0] RSP_SYNC  = 8'h5A;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] CODE_OK   = 8'h00;
  localparam logic [7:0] CODE_CSUM = 8'hE1;
  localparam logic [7:0] CODE_CMD  = 8'hE2;
  localparam logic [7:0] CODE_ADDR = 8'hE3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_EXEC,
    S_SEND,
    S_GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [7:0]      r_cmd;
  logic [7:0]      r_addr;
  logic [7:0]      r_data;
  logic [7:0]      r_code;
  logic [7:0]      r_payload;
  logic [TW-1:0]   r_tmo;
  logic [2:0]      r_idx;
  logic [7:0]      r_regs [NREG];
  logic            r_tx_vld;
  logic [7:0]      r_tx_data;
  logic            r_wr_stb;
  logic            r_busy;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic            w_in_frame;
  logic            w_tmo_hit;
  logic            w_addr_ok;
  logic [7:0]      w_exp_csum;
  logic [7:0]      w_rd_val;
  logic [7:0]      w_code;
  logic [7:0]      w_payload;
  logic [7:0]      w_tx_byte;

  assign w_in_frame = (r_state == S_CMD)  || (r_state == S_ADDR) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_tmo_hit  = (r_tmo == TMO_MAX);
  assign w_addr_ok  = (int'(r_addr) < NREG);

  // Read mux over the bank. An out-of-range address simply selects nothing;
  // the E3 path never uses the value.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_rd_val = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      if (r_addr == i[7:0]) w_rd_val = r_regs[i];
    end
  end

  // Request evaluation. It runs while the CSUM byte is on rx_data so that
  // CODE/PAYLOAD and the write strobe are already registered during EXEC;
  // nothing can change the bank between that byte and EXEC.
  always_comb begin
    w_exp_csum = r_cmd ^ r_addr ^ ((r_cmd == CMD_WR) ? r_data : 8'h00);
    w_code     = CODE_OK;
    w_payload  = 8'h00;
    if (rx_data != w_exp_csum) begin
      w_code = CODE_CSUM;
    end else if ((r_cmd != CMD_WR) && (r_cmd != CMD_RD)) begin
      w_code = CODE_CMD;
    end else if (!w_addr_ok) begin
      w_code = CODE_ADDR;
    end else if (r_cmd == CMD_WR) begin
      w_payload = r_data;
    end else begin
      w_payload = w_rd_val;
    end
  end

  // Response byte selected by the byte index.
  always_comb begin
    case (r_idx[1:0])
      2'd0:    w_tx_byte = RSP_SYNC;
      2'd1:    w_tx_byte = r_code;
      2'd2:    w_tx_byte = r_payload;
      default: w_tx_byte = r_code ^ r_payload;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Parser / executor / sender FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cmd     <= 8'h00;
      r_addr    <= 8'h00;
      r_data    <= 8'h00;
      r_code    <= 8'h00;
      r_payload <= 8'h00;
      r_tmo     <= '0;
      r_idx     <= 3'd0;
      r_tx_vld  <= 1'b0;
      r_tx_data <= 8'h00;
      r_wr_stb  <= 1'b0;
      r_busy    <= 1'b0;
      // NOTE: the bank is a set of flops with a defined reset value, not a
      // RAM, so it is cleared here along with the rest of the state.
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // read in this block sees the value from before the clock edge.
      r_tx_vld <= 1'b0;
      r_wr_stb <= 1'b0;

      if (w_in_frame && w_tmo_hit) begin
        // Timeout wins over a byte arriving in the same cycle.
        r_state <= S_IDLE;
        r_tmo   <= '0;
      end else begin
        if (w_in_frame) begin
          r_tmo <= rx_vld ? '0 : r_tmo + TW'(1);
        end

        case (r_state)
          S_IDLE: begin
            r_tmo <= '0;
            if (rx_vld && (rx_data == REQ_SYNC)) r_state <= S_CMD;
          end

          S_CMD: begin
            if (rx_vld) begin
              r_cmd   <= rx_data;
              r_state <= S_ADDR;
            end
          end

          S_ADDR: begin
            if (rx_vld) begin
              r_addr  <= rx_data;
              r_state <= (r_cmd == CMD_WR) ? S_DATA : S_CSUM;
            end
          end

          S_DATA: begin
            if (rx_vld) begin
              r_data  <= rx_data;
              r_state <= S_CSUM;
            end
          end

          S_CSUM: begin
            if (rx_vld) begin
              r_code    <= w_code;
              r_payload <= w_payload;
              r_wr_stb  <= (w_code == CODE_OK) && (r_cmd == CMD_WR);
              r_busy    <= 1'b1;
              r_state   <= S_EXEC;
            end
          end

          S_EXEC: begin
            // wr_stb is high in this cycle; the bank updates at its end.
            if (r_wr_stb) begin
              for (int i = 0; i < NREG; i++) begin
                if (r_addr == i[7:0]) r_regs[i] <= r_data;
              end
            end
            r_idx   <= 3'd0;
            r_state <= S_SEND;
          end

          S_SEND: begin
            if (txrdy) begin
              r_tx_vld  <= 1'b1;
              r_tx_data <= w_tx_byte;
              r_idx     <= r_idx + 3'd1;
              r_state   <= S_GAP;
            end
          end

          S_GAP: begin
            // One dead cycle covers the transmitter's late drop of txrdy.
            if (r_idx == 3'd4) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_SEND;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx_vld  = r_tx_vld;
  assign tx_data = r_tx_data;
  assign wr_stb  = r_wr_stb;
  assign busy    = r_busy;

  for (genvar g = 0; g < NREG; g++) begin : g_reg_q
    assign reg_q[8*g +: 8] = r_regs[g];
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_responder
//
// Drives request frames into uart_reg_responder and compares every response
// against a frame-level reference model (an array of register values plus
// the request/response rules). A transmitter model answers tx_vld by holding
// txrdy low for a random number of cycles, and checks the strobe protocol.
// -----------------------------------------------------------------------------
module tb_uart_reg_responder;

  localparam int NREG        = 8;
  localparam int TIMEOUT     = 60;
  localparam int RESP_BUDGET = 30000;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_vld;
  logic [7:0]        rx_data;
  logic              txrdy;
  logic              tx_vld;
  logic [7:0]        tx_data;
  logic [8*NREG-1:0] reg_q;
  logic              wr_stb;
  logic              busy;

  uart_reg_responder #(.NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_vld  (rx_vld),
    .rx_data (rx_data),
    .txrdy   (txrdy),
    .tx_vld  (tx_vld),
    .tx_data (tx_data),
    .reg_q   (reg_q),
    .wr_stb  (wr_stb),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int         n_checks    = 0;
  int         n_fail      = 0;
  int         cyc         = 0;
  int         wr_cnt      = 0;
  int         hold_min    = 0;
  int         hold_max    = 3;
  int         last_strobe = -1;
  logic [7:0] tx_q [$];
  logic [7:0] mdl [NREG];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [8*NREG-1:0] mdl_packed();
    logic [8*NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[8*i +: 8] = mdl[i];
    return v;
  endfunction

  // Transmitter model and output monitor, sampled on the falling edge.
  initial begin
    int hold = 0;
    txrdy = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        txrdy       = 1'b1;
        hold        = 0;
        last_strobe = -1;
      end else begin
        if (wr_stb) wr_cnt++;
        if (tx_vld) begin
          check("txrdy_at_strobe", 64'(txrdy), 64'd1);
          if (last_strobe >= 0) check("strobe_spacing", 64'((cyc - last_strobe) >= 2), 64'd1);
          last_strobe = cyc;
          tx_q.push_back(tx_data);
          txrdy = 1'b0;
          hold  = int'($urandom_range(hold_max, hold_min));
        end else if (!txrdy) begin
          if (hold == 0) txrdy = 1'b1;
          else hold--;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pause(input int gap);
    if (gap < 0) idle(int'($urandom_range(3, 1)));
    else idle(gap);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk);
    #1;
    rx_vld  = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // Waits for four response bytes and compares them; busy must already be
  // low in the cycle after the fourth strobe.
  task automatic wait_resp(input logic [7:0] code, input logic [7:0] payload);
    logic [7:0] exp_b [4];
    logic [7:0] got;
    int t;
    exp_b[0] = 8'h5A;
    exp_b[1] = code;
    exp_b[2] = payload;
    exp_b[3] = code ^ payload;
    t = 0;
    while (tx_q.size() < 4 && t < RESP_BUDGET) begin
      idle(1);
      t++;
    end
    check("resp_complete", 64'(tx_q.size() >= 4), 64'd1);
    for (int k = 0; k < 4; k++) begin
      got = 8'hxx;
      if (tx_q.size() > 0) got = tx_q.pop_front();
      check($sformatf("resp_byte%0d", k), 64'(got), 64'(exp_b[k]));
    end
    check("busy_fall", 64'(busy), 64'd0);
    check("extra_tx", 64'(tx_q.size()), 64'd0);
  endtask

  // Sends one request frame, checks the EXEC/commit cycles and the response.
  task automatic send_cmd(input logic [7:0] cmd, input logic [7:0] addr,
                          input logic [7:0] data, input logic [7:0] csum,
                          input bit inject, input int gap);
    logic [7:0]        exp_cs;
    logic [7:0]        code;
    logic [7:0]        payload;
    logic              do_wr;
    logic [8*NREG-1:0] old_q;
    logic [7:0]        junk [4];
    int                wr_before;

    exp_cs  = (cmd == 8'h01) ? (cmd ^ addr ^ data) : (cmd ^ addr);
    do_wr   = 1'b0;
    payload = 8'h00;
    if (csum != exp_cs)                    code = 8'hE1;
    else if (cmd != 8'h01 && cmd != 8'h02) code = 8'hE2;
    else if (int'(addr) >= NREG)           code = 8'hE3;
    else begin
      code = 8'h00;
      if (cmd == 8'h01) begin
        payload = data;
        do_wr   = 1'b1;
      end else begin
        payload = mdl[int'(addr)];
      end
    end
    old_q = mdl_packed();
    if (do_wr) mdl[int'(addr)] = data;
    wr_before = wr_cnt;

    send_byte(8'hA5); pause(gap);
    send_byte(cmd);   pause(gap);
    send_byte(addr);  pause(gap);
    if (cmd == 8'h01) begin
      send_byte(data); pause(gap);
    end
    check("busy_before_csum", 64'(busy), 64'd0);
    send_byte(csum);
    check("busy_rise", 64'(busy), 64'd1);
    check("wr_stb_exec", 64'(wr_stb), 64'(do_wr));
    check("reg_q_in_exec", 64'(reg_q), 64'(old_q));
    idle(1);
    check("wr_stb_after", 64'(wr_stb), 64'd0);
    check("reg_q_commit", 64'(reg_q), 64'(mdl_packed()));

    if (inject) begin
      junk[0] = 8'hA5; junk[1] = 8'h02; junk[2] = 8'h00; junk[3] = 8'h02;
      for (int k = 0; k < 4; k++) begin
        idle(2);
        send_byte(junk[k]);
      end
    end

    wait_resp(code, payload);
    check("wr_count", 64'(wr_cnt - wr_before), 64'(do_wr));
  endtask

  initial begin
    logic [7:0] c, a, d, s;
    int t;

    rst     = 1'b1;
    rx_vld  = 1'b0;
    rx_data = 8'h00;
    for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    check("rst_tx_vld", 64'(tx_vld), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_wr_stb", 64'(wr_stb), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_reg_q", 64'(reg_q), 64'd0);

    // Write then read back.
    send_cmd(8'h01, 8'h03, 8'h5C, 8'h5E, 1'b0, -1);
    send_cmd(8'h02, 8'h03, 8'h00, 8'h01, 1'b0, -1);

    // Error codes.
    send_cmd(8'h01, 8'h03, 8'h5C, 8'h00, 1'b0, -1);
    send_cmd(8'h02, 8'h09, 8'h00, 8'h0B, 1'b0, -1);
    send_cmd(8'h07, 8'h00, 8'h00, 8'h07, 1'b0, -1);
    send_cmd(8'h07, 8'h09, 8'h00, 8'h00, 1'b0, -1);

    // Sync hunting and an abandoned frame.
    send_byte(8'h11); idle(2);
    send_byte(8'h22); idle(2);
    send_byte(8'hA5); idle(2);
    send_byte(8'h01);
    idle(TIMEOUT + 2);
    check("no_resp_garbage", 64'(tx_q.size()), 64'd0);
    send_cmd(8'h02, 8'h00, 8'h00, 8'h02, 1'b0, -1);

    // Byte arriving exactly as the timeout fires is discarded.
    send_byte(8'hA5);
    idle(TIMEOUT);
    send_byte(8'h02);
    idle(3);
    check("no_resp_tmo_tie", 64'(tx_q.size()), 64'd0);
    send_cmd(8'h02, 8'h03, 8'h00, 8'h01, 1'b0, -1);

    // Bytes one cycle inside the timeout are still accepted.
    send_cmd(8'h01, 8'h07, 8'hC3, 8'h01 ^ 8'h07 ^ 8'hC3, 1'b0, TIMEOUT - 1);

    // Handshake stress with a slow transmitter.
    hold_min = 100; hold_max = 2000;
    d = 8'($urandom);
    send_cmd(8'h01, 8'h05, d, 8'h01 ^ 8'h05 ^ d, 1'b0, -1);
    send_cmd(8'h02, 8'h05, 8'h00, 8'h07, 1'b0, -1);

    // Half duplex: bytes during the response are dropped.
    hold_min = 100; hold_max = 400;
    send_cmd(8'h01, 8'h06, 8'h3C, 8'h01 ^ 8'h06 ^ 8'h3C, 1'b1, -1);
    idle(TIMEOUT + 10);
    check("no_resp_injected", 64'(tx_q.size()), 64'd0);

    // Randomized frames.
    hold_min = 0; hold_max = 5;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(9, 0))
        0, 1, 2, 3: c = 8'h01;
        4, 5, 6, 7: c = 8'h02;
        8:          c = 8'($urandom);
        default:    c = 8'h00;
      endcase
      a = 8'($urandom_range(NREG + 3, 0));
      d = 8'($urandom);
      s = (c == 8'h01) ? (c ^ a ^ d) : (c ^ a);
      if ($urandom_range(4, 0) == 0) s = 8'($urandom);
      send_cmd(c, a, d, s, 1'b0, -1);
    end

    // Reset between the 2nd and 3rd response strobe.
    send_cmd(8'h01, 8'h03, 8'h5C, 8'h5E, 1'b0, -1);
    hold_min = 30; hold_max = 60;
    send_byte(8'hA5); idle(1);
    send_byte(8'h02); idle(1);
    send_byte(8'h03); idle(1);
    send_byte(8'h01);
    t = 0;
    while (tx_q.size() < 2 && t < RESP_BUDGET) begin
      idle(1);
      t++;
    end
    check("two_strobes_seen", 64'(tx_q.size()), 64'd2);
    rst = 1'b1;
    #2;
    check("midrst_tx_vld", 64'(tx_vld), 64'd0);
    check("midrst_tx_data", 64'(tx_data), 64'd0);
    check("midrst_wr_stb", 64'(wr_stb), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_reg_q", 64'(reg_q), 64'd0);
    idle(3);
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
    check("partial_byte0", 64'(tx_q.pop_front()), 64'h5A);
    check("partial_byte1", 64'(tx_q.pop_front()), 64'h00);
    idle(200);
    check("no_tx_after_rst", 64'(tx_q.size()), 64'd0);
    hold_min = 0; hold_max = 3;
    send_cmd(8'h02, 8'h03, 8'h00, 8'h01, 1'b0, -1);
    send_cmd(8'h01, 8'h02, 8'h77, 8'h01 ^ 8'h02 ^ 8'h77, 1'b0, -1);
    send_cmd(8'h02, 8'h02, 8'h00, 8'h00, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Byte-level command responder that sits on the host side of the UART transceiver. It consumes received bytes (`rx_vld`/`rx_data`), parses fixed-format register read/write frames, executes them against an internal register bank, and returns a 4-byte response frame through the transmit handshake (`tx_vld`/`tx_data`/`txrdy`). It is the far end of the serial link: a PC-side initiator sends commands, and this block answers.

## Interface
Parameters:
- `NREG`, 8: number of 8-bit registers; legal addresses are 0..NREG-1 (NREG ≤ 256).
- `TIMEOUT`, 50000: maximum idle clocks between bytes of one command frame before the parser aborts.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_vld` in 1: single-cycle strobe, received byte valid.
- `rx_data` in 8: received byte, sampled when `rx_vld`=1.
- `txrdy` in 1: transmitter idle; it falls the cycle after it samples `tx_vld`=1.
- `tx_vld` out 1: registered single-cycle byte-send strobe.
- `tx_data` out 8: registered byte to send; held stable from the strobe until the next strobe.
- `reg_q` out 8*NREG: register bank, reg i on bits [8i+7:8i].
- `wr_stb` out 1: one-cycle pulse on each committed register write.
- `busy` out 1: high from frame-complete until the last response byte is handed off.

## Operation
- Request frame: `0xA5` (sync), CMD, ADDR, [DATA], CSUM.
  - CMD `0x01` is a write and includes DATA. CSUM = CMD^ADDR^DATA.
  - CMD `0x02` is a read and has no DATA. CSUM = CMD^ADDR.
- Response frame is always 4 bytes: `0x5A`, CODE, PAYLOAD, CODE^PAYLOAD.
  - Write OK: CODE `0x00`, PAYLOAD = written data.
  - Read OK: CODE `0x00`, PAYLOAD = `reg[ADDR]`.
  - Errors: PAYLOAD `0x00`, with CODE `0xE1` for bad checksum, `0xE2` for unknown CMD, `0xE3` for ADDR ≥ NREG.
- Error priority: `E1` > `E2` > `E3`. The checksum is checked first.
- An unknown CMD takes the read length (the next byte after ADDR is CSUM).
- FSM states: IDLE, CMD, ADDR, DATA, CSUM, EXEC, SEND, GAP.
  - IDLE: a byte of `0xA5` goes to CMD. Any other byte is discarded.
  - CMD → ADDR → (DATA if CMD=`0x01`) → CSUM. Each step advances on `rx_vld`.
  - CSUM byte received → EXEC.
  - EXEC (1 cycle): evaluate errors, commit the write if there is no error (`wr_stb`=1 in this cycle, register updates at the end of EXEC), latch CODE/PAYLOAD, set byte index=0 → SEND.
  - SEND: when `txrdy`=1, drive `tx_vld`=1 and `tx_data`=byte[index] on the next cycle, increment index → GAP.
  - GAP: exactly 1 cycle, ignores `txrdy`. This covers the cycle before the transmitter drops `txrdy`. Then go to SEND if index<4, else IDLE.
- Timeout counter:
  - Runs in CMD/ADDR/DATA/CSUM and clears on every `rx_vld`.
  - Reaching TIMEOUT returns the FSM to IDLE with no response and no write.
- Half duplex: `rx_vld` in EXEC/SEND/GAP is ignored and the byte is dropped.
- Reset values:
  - `tx_vld`=0, `tx_data`=`0x00`, `wr_stb`=0, `busy`=0.
  - All registers `0x00`, FSM=IDLE, timeout and index counters 0.
- Reset mid-frame or mid-response: abort immediately; no partial write survives except writes already committed.

## Timing
- Write latency: `reg_q` reflects new data on the cycle after EXEC, which is 2 cycles after the CSUM `rx_vld`.
- First `tx_vld` occurs at the earliest 2 cycles after EXEC, given `txrdy`=1.
- Consecutive `tx_vld` pulses are never closer than 2 cycles apart. There is never a `tx_vld` while `txrdy`=0.
- `tx_vld` is high for exactly one cycle per byte. Exactly 4 pulses occur per completed frame.
- `busy` rises on the cycle after the CSUM byte and falls on the cycle after the 4th `tx_vld`.
- Timeout compare uses a counter of width ⌈log2(TIMEOUT+1)⌉. No wrap is possible, since the counter saturates at TIMEOUT.
- `rx_vld` arriving in the same cycle the timeout fires: the timeout wins. The FSM goes to IDLE and that byte is discarded.

## Test plan
- Write then read:
  - Send `A5 01 03 5C 5E` → `wr_stb` pulse, reg3=`0x5C`, response `5A 00 5C 5C`.
  - Then send `A5 02 03 01` → response `5A 00 5C 5C`.
- Bad checksum: send `A5 01 03 5C 00` → response `5A E1 00 E1`; reg3 unchanged; no `wr_stb`.
- Bad address and bad command:
  - Send `A5 02 09 0B` (NREG=8) → response `5A E3 00 E3`.
  - Send `A5 07 00 07` → response `5A E2 00 E2`.
- Sync hunting and timeout:
  - Send `11 22 A5 01`, then no bytes for TIMEOUT+2 cycles, then `A5 02 00 02` → a single response `5A 00 00 00`.
- Handshake stress:
  - Model a transmitter that holds `txrdy` low for a random 100–2000 cycles after each strobe → exactly 4 strobes, none while `txrdy`=0, strobes ≥2 cycles apart.
  - Inject `rx_vld` bytes during SEND → the bytes are ignored.
- Reset mid-response: assert `rst` between the 2nd and 3rd `tx_vld` → all outputs and registers return to reset values; no further `tx_vld`; the next valid frame is served normally.
